alu_result_fifo: RTL
====================

// Module: alu_result_fifo
// PURPOSE
//  Downstream stage of the ALU arithmetic unit. Captures every registered
//  arithmetic result, {Carry_OUT, Arith_OUT}, in the cycle Arith_Flag is high.
//  Buffers results in a small FIFO and hands them to the consumer over a
//  valid/ready handshake, so back-pressure never loses results silently.
//  Flags results dropped because the buffer was full.
// PARAMETERS
//  Width  16  data width; must equal the arithmetic unit Width
//  Depth  4   FIFO entries; power of 2, >= 2
//  (local) AW = $clog2(Depth): pointer width; count width is AW+1
// PORTS
//  CLK        in   1      clock; all state updates on rising edge
//  RST        in   1      reset; synchronous, active-low, sampled on CLK rise
//  Arith_OUT  in   Width  result data from arithmetic unit
//  Carry_OUT  in   1      result carry from arithmetic unit
//  Arith_Flag in   1      result valid; 1 = push {Carry_OUT,Arith_OUT} this cycle
//  Out_Ready  in   1      consumer ready
//  Clr_Ovf    in   1      clears the Overflow flag
//  Out_Valid  out  1      head entry valid (Count != 0)
//  Out_Data   out  Width  head entry data
//  Out_Carry  out  1      head entry carry
//  Count      out  AW+1   number of stored entries, 0..Depth
//  Full       out  1      Count == Depth
//  Overflow   out  1      sticky; a push was dropped
// BEHAVIOUR
//  - Reset (RST=0 at CLK rise):
//    - rd_ptr=wr_ptr=0; Count=0; Overflow=0.
//    - Out_Valid=0, Full=0, Out_Data=0, Out_Carry=0.
//    - Storage array is not cleared.
//    - Reset wins over all pushes and pops in that cycle.
//  - Push request: push_req = Arith_Flag.
//  - Pop: pop = Out_Valid & Out_Ready.
//  - Push accepted: push = push_req & (!Full | pop).
//    - Write entry wr_ptr = {Carry_OUT, Arith_OUT}; wr_ptr += 1 mod Depth.
//  - Pop completes: rd_ptr += 1 mod Depth.
//  - Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Full: a push while Full with a pop in the same cycle is accepted.
//    Count stays at Depth.
//  - Full: a push while Full with no pop is dropped.
//    Storage and pointers stay unchanged; Overflow <= 1.
//  - Overflow: stays 1 until Clr_Ovf=1 at a CLK rise.
//    If Clr_Ovf and a new drop occur in the same cycle, Overflow = 1 (set wins).
//  - Empty: Out_Valid=0; Out_Data and Out_Carry hold 0.
//    Out_Ready is ignored.
//    A push in this cycle gives Out_Valid=1 after the same edge (latency 1 clk).
//    There is no same-cycle bypass.
//  - Out_Valid, Out_Data, Out_Carry, Count, Full, Overflow: derived only from
//    registers; no combinational path from any input.
//  - Ordering: strict FIFO; pointers wrap from Depth-1 to 0.
//  - Stability: with Out_Valid=1 and Out_Ready=0, Out_Data and Out_Carry stay
//    stable until a pop.
//  - Reset mid-operation: all held results are discarded; Out_Valid=0 on the
//    next cycle.
// TESTING
//  1. Single push: RST released; Arith_Flag=1 for 1 clk with Arith_OUT=16'h0005,
//     Carry=0, Out_Ready=0.
//     -> next cycle Out_Valid=1, Out_Data=5, Count=1.
//     Then Out_Ready=1 for 1 clk -> Count=0, Out_Valid=0.
//  2. Fill and overflow: Out_Ready=0; push 1,2,3,4 -> Full=1, Count=4.
//     Push 5 -> Overflow=1, Count=4.
//     Drain -> outputs 1,2,3,4 in order; entry 5 is absent.
//  3. Push and pop while full: Full; push 16'hAAAA with Out_Ready=1 in the same clk.
//     -> Count stays 4, Overflow stays 0, head advances.
//     16'hAAAA is the last entry drained.
//  4. Wrap-around: 10 push/pop pairs, values 0..9, Carry toggling.
//     -> each entry popped matches its pushed data and carry; Count never
//        exceeds 1; pointers wrap.
//  5. Overflow clear: Overflow=1; Clr_Ovf=1 for 1 clk with no push -> Overflow=0.
//     Repeat with a dropped push in the same clk -> Overflow stays 1.
//  6. Reset mid-operation: Count=3; RST=0 for 1 clk with Arith_Flag=1.
//     -> Count=0, Out_Valid=0, Overflow=0; the push in the reset cycle is not
//        stored.

Source files
------------

// File: rtl/alu_result_fifo.sv
// Result buffer behind the ALU arithmetic unit: captures {Carry_OUT, Arith_OUT}
// on Arith_Flag and presents them FIFO-ordered over a valid/ready handshake.
module alu_result_fifo #(
   parameter int unsigned Width = 16,
   parameter int unsigned Depth = 4,
   localparam int unsigned AW = $clog2(Depth)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [Width-1:0] Arith_OUT,
   input  logic             Carry_OUT,
   input  logic             Arith_Flag,
   input  logic             Out_Ready,
   input  logic             Clr_Ovf,
   output logic             Out_Valid,
   output logic [Width-1:0] Out_Data,
   output logic             Out_Carry,
   output logic [AW:0]      Count,
   output logic             Full,
   output logic             Overflow
);

   localparam logic [AW:0] DEPTH_C = (AW + 1)'(Depth);

   logic [Width:0]  mem_q [Depth];
   logic [AW-1:0]   wr_q, wr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            pop, push, drop;
   logic [Width:0]  head;

   assign Out_Valid = (cnt_q != '0);
   assign Full      = (cnt_q == DEPTH_C);
   assign Count     = cnt_q;
   assign Overflow  = ovf_q;
   assign head      = mem_q[rd_q];
   // Storage is never cleared, so the head is masked to 0 while empty.
   assign Out_Data  = Out_Valid ? head[Width-1:0] : '0;
   assign Out_Carry = Out_Valid ? head[Width] : 1'b0;

   always_comb begin
      pop   = Out_Valid & Out_Ready;
      push  = Arith_Flag & (~Full | pop);
      drop  = Arith_Flag & Full & ~pop;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      if (drop)         ovf_d = 1'b1;
      else if (Clr_Ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST && push) mem_q[wr_q] <= {Carry_OUT, Arith_OUT};
   end

endmodule
